// File: rtl/phase_sample_averager.sv
// Block averager between the detector FIFO and the serialiser: reads 2**LOG2_SAMPLES phase words,
// sends their mean. Define PHASE_AVG_ROUND_EN for round-half-up, otherwise the mean is truncated.
module phase_sample_averager #(
    parameter int DATA_WIDTH   = 16,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  tx_ready,
    output logic                  tx_go,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WAIT1   = 3'd2,
        S_CAPTURE = 3'd3,
        S_SEND    = 3'd4
    } state_t;

    localparam int N  = 2 ** LOG2_SAMPLES;
    localparam int CW = LOG2_SAMPLES + 1;
`ifdef PHASE_AVG_ROUND_EN
    localparam int SW = DATA_WIDTH + LOG2_SAMPLES + 1;
`else
    localparam int SW = DATA_WIDTH + LOG2_SAMPLES;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(N);

    state_t                  r_state;
    logic [SW-1:0]           r_sum;
    logic [CW-1:0]           r_count;
    logic                    r_rd_en;
    logic                    r_tx_go;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_busy;
    logic [DATA_WIDTH-1:0]   w_result;

`ifdef PHASE_AVG_ROUND_EN
    // N/2 is zero when LOG2_SAMPLES=0, so single-word blocks pass through unchanged.
    localparam logic [SW-1:0] HALF = SW'(N / 2);
    logic [SW-1:0] w_sum_rnd;
    logic [SW-1:0] w_shifted;
    assign w_sum_rnd = r_sum + HALF;
    assign w_shifted = w_sum_rnd >> LOG2_SAMPLES;
    assign w_result  = (|w_shifted[SW-1:DATA_WIDTH]) ? '1 : w_shifted[DATA_WIDTH-1:0];
`else
    assign w_result  = r_sum[SW-1:LOG2_SAMPLES];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sum     <= '0;
            r_count   <= '0;
            r_rd_en   <= 1'b0;
            r_tx_go   <= 1'b0;
            r_tx_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_tx_go <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!fifo_empty && (r_count < FULL_CNT)) begin
                        r_state <= S_READ;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT1;
                end
                // Non-FWFT FIFO: data requested in READ is on the bus in CAPTURE.
                S_WAIT1: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_sum   <= r_sum + SW'(fifo_data);
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST_IDX) begin
                        r_state <= S_SEND;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        r_tx_go   <= 1'b1;
                        r_tx_data <= w_result;
                        r_sum     <= '0;
                        r_count   <= '0;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en  = r_rd_en;
    assign tx_go       = r_tx_go;
    assign tx_data     = r_tx_data;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule
